sar_adc_ctrl: RTL and testbench
===============================

// Module: sar_adc_ctrl
// PURPOSE
//   Digital successive-approximation controller for the on-die analog SAR ADC.
//   Sits directly upstream of the analog core: drives its sample switch and
//   capacitor-DAC code, consumes its comparator decision, and returns a
//   WIDTH-bit result with a one-cycle valid strobe to the digital top.
// PARAMETERS
//   WIDTH          8   result / DAC code width in bits (>=2)
//   SAMPLE_CYCLES  4   cycles sample_en is held high per conversion (>=1)
//   SETTLE_CYCLES  1   extra DAC settle cycles before each comparison (>=0)
// PORTS
//   clk        in   1      system clock; the single clock of this block
//   rst        in   1      synchronous reset, active-high
//   start      in   1      request a conversion; level, sampled on clk
//   comp_in    in   1      comparator output, synchronous to clk; 1 = Vin >= Vdac
//   sample_en  out  1      closes the analog sample switch
//   dac_code   out  WIDTH  trial code to the capacitor DAC
//   busy       out  1      high from the cycle after start is accepted through DONE
//   result     out  WIDTH  last completed conversion; holds until the next one
//   valid      out  1      one-cycle pulse: result updated this cycle
// BEHAVIOUR
//   - All outputs registered. Reset: state=IDLE, sample_en=0, dac_code=0,
//     busy=0, result=0, valid=0; rst has priority over every other input.
//   - States: IDLE, SAMPLE, CONV, DONE.
//   - IDLE: start=1 at an edge -> SAMPLE; busy=1, sample_en=1, dac_code=0.
//   - SAMPLE: lasts exactly SAMPLE_CYCLES cycles; on its last edge -> CONV,
//     sample_en=0, bit index i=WIDTH-1, dac_code = 1<<(WIDTH-1).
//   - CONV: each bit lasts SETTLE_CYCLES+1 cycles. On the bit's last edge
//     comp_in is sampled: 1 keeps bit i, 0 clears it; if i>0 bit i-1 is set
//     in the same edge (dac_code = kept_bits | 1<<(i-1)), i decrements.
//   - After the LSB decision: -> DONE; result = final code, valid=1,
//     dac_code returns to 0. DONE lasts one cycle, then -> IDLE, valid=0,
//     busy=0.
//   - Latency: valid is high SAMPLE_CYCLES + WIDTH*(SETTLE_CYCLES+1) edges
//     after the edge that accepted start (defaults: 20).
//   - start is ignored in SAMPLE and CONV (no queueing). start=1 in DONE is
//     accepted: next state SAMPLE, busy stays high, back-to-back conversions
//     with no IDLE cycle.
//   - comp_in is ignored outside the decision edge of each bit.
//   - Index/settle counters are internal; widths sized by $clog2, no wrap.
//   - rst mid-conversion: next cycle all outputs at reset values, result
//     cleared to 0, no valid pulse for the aborted conversion.
//   - dac_code only changes on decision edges or state entry; never glitches
//     between (registered output).
// TESTING
//   1. Comparator model Vin code 0xA5, start 1 cycle -> dac_code trace
//      0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5; result=0xA5, valid at edge 20.
//   2. comp_in tied 1 -> result=0xFF; comp_in tied 0 -> result=0x00; one valid each.
//   3. start held high 60 cycles, Vin=0x3C -> valid pulses at edges 20,41,62
//      spacing 21, busy never drops between, each result=0x3C.
//   4. start pulsed again at edge 5 and 12 of a conversion -> ignored; exactly
//      one valid, latency unchanged.
//   5. rst asserted at edge 10 of a conversion -> next cycle sample_en=0,
//      dac_code=0, busy=0, result=0, valid never pulses; fresh start works.
//   6. SETTLE_CYCLES=0, SAMPLE_CYCLES=1, Vin=0x01 -> result=0x01, valid at edge 9.

Source files
------------

// File: rtl/sar_adc_ctrl.sv
// rtl/sar_adc_ctrl.sv - successive-approximation controller for the on-die SAR ADC
// Drives sample switch and cap-DAC trial code, returns a registered result with a valid strobe.
module sar_adc_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             comp_in,
  output logic             sample_en,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             valid
);
  localparam int SCW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam int STW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int IW  = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SAMPLE, CONV, DONE} state_t;

  state_t           state, state_n;
  logic [SCW-1:0]   scnt, scnt_n;
  logic [STW-1:0]   tcnt, tcnt_n;
  logic [IW-1:0]    idx, idx_n;
  logic             sample_en_n, busy_n, valid_n;
  logic [WIDTH-1:0] dac_n, result_n, kept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      scnt      <= '0;
      tcnt      <= '0;
      idx       <= '0;
      sample_en <= 1'b0;
      dac_code  <= '0;
      busy      <= 1'b0;
      result    <= '0;
      valid     <= 1'b0;
    end else begin
      state     <= state_n;
      scnt      <= scnt_n;
      tcnt      <= tcnt_n;
      idx       <= idx_n;
      sample_en <= sample_en_n;
      dac_code  <= dac_n;
      busy      <= busy_n;
      result    <= result_n;
      valid     <= valid_n;
    end
  end

  always_comb begin
    state_n     = state;
    scnt_n      = scnt;
    tcnt_n      = tcnt;
    idx_n       = idx;
    sample_en_n = sample_en;
    dac_n       = dac_code;
    busy_n      = busy;
    result_n    = result;
    valid_n     = 1'b0;
    kept        = dac_code;
    case (state)
      IDLE: begin
        if (start) begin
          state_n     = SAMPLE;
          busy_n      = 1'b1;
          sample_en_n = 1'b1;
          dac_n       = '0;
          scnt_n      = '0;
        end
      end
      SAMPLE: begin
        if (scnt == SCW'(SAMPLE_CYCLES - 1)) begin
          state_n     = CONV;
          sample_en_n = 1'b0;
          idx_n       = IW'(WIDTH - 1);
          dac_n       = WIDTH'(1) << (WIDTH - 1);
          tcnt_n      = '0;
        end else begin
          scnt_n = scnt + 1'b1;
        end
      end
      CONV: begin
        // comp_in only matters on the final cycle of each bit's settle window
        if (tcnt == STW'(SETTLE_CYCLES)) begin
          tcnt_n = '0;
          if (!comp_in) kept[idx] = 1'b0;
          if (idx == '0) begin
            state_n  = DONE;
            result_n = kept;
            valid_n  = 1'b1;
            dac_n    = '0;
          end else begin
            kept[idx - 1'b1] = 1'b1;
            dac_n            = kept;
            idx_n            = idx - 1'b1;
          end
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_n     = SAMPLE;
          sample_en_n = 1'b1;
          dac_n       = '0;
          scnt_n      = '0;
        end else begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb/tb_sar_adc_ctrl.sv - randomized bench for sar_adc_ctrl against a phase-arithmetic model
// Two instances: default timing (4,1) and fast timing (1,0) share start/rst stimulus.
module tb_sar_adc_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] vin_next = 8'h00;
  logic       noise [2];
  logic       comp_in [2];
  logic       sample_en [2];
  logic [7:0] dac_code [2];
  logic       busy [2];
  logic [7:0] result [2];
  logic       valid [2];

  int pass_cnt = 0;
  int total_cnt = 0;
  bit checking = 0;

  always #5 clk = ~clk;

  sar_adc_ctrl #(.WIDTH(8), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .comp_in(comp_in[0]),
    .sample_en(sample_en[0]), .dac_code(dac_code[0]), .busy(busy[0]),
    .result(result[0]), .valid(valid[0]));

  sar_adc_ctrl #(.WIDTH(8), .SAMPLE_CYCLES(1), .SETTLE_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .comp_in(comp_in[1]),
    .sample_en(sample_en[1]), .dac_code(dac_code[1]), .busy(busy[1]),
    .result(result[1]), .valid(valid[1]));

  function automatic int samp_of(int i);
    return (i == 0) ? 4 : 1;
  endfunction
  function automatic int settle_of(int i);
    return (i == 0) ? 1 : 0;
  endfunction
  function automatic int lat_of(int i);
    return samp_of(i) + 8 * (settle_of(i) + 1);
  endfunction

  // Trial code for bit j: bits of vin above j kept, bit j set, rest clear.
  function automatic logic [7:0] trial(int k, int i, logic [7:0] v);
    int j, b;
    j = (k - samp_of(i)) / (settle_of(i) + 1);
    b = 1 << (7 - j);
    return 8'((int'(v) & ~((b << 1) - 1)) | b);
  endfunction

  // Model: phase k = edges since the accepting edge of the current conversion.
  bit         m_active [2] = '{0, 0};
  int         m_k [2]      = '{0, 0};
  logic [7:0] m_vin [2]    = '{8'h00, 8'h00};
  logic [7:0] m_res [2]    = '{8'h00, 8'h00};

  logic       e_sample [2];
  logic [7:0] e_dac [2];
  logic       e_busy [2];
  logic       e_valid [2];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      e_sample[i] = 1'b0;
      e_dac[i]    = 8'h00;
      e_busy[i]   = 1'b0;
      e_valid[i]  = 1'b0;
      comp_in[i]  = noise[i];
      if (m_active[i]) begin
        e_busy[i] = 1'b1;
        if (m_k[i] < samp_of(i)) e_sample[i] = 1'b1;
        else if (m_k[i] < lat_of(i)) begin
          e_dac[i] = trial(m_k[i], i, m_vin[i]);
          if ((m_k[i] + 1 - samp_of(i)) % (settle_of(i) + 1) == 0)
            comp_in[i] = (m_vin[i] >= e_dac[i]);
        end else e_valid[i] = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_active[i] <= 0;
        m_k[i]      <= 0;
        m_res[i]    <= 8'h00;
      end else if (!m_active[i] || m_k[i] == lat_of(i)) begin
        m_active[i] <= start;
        m_k[i]      <= 0;
        if (start) m_vin[i] <= vin_next;
      end else begin
        m_k[i] <= m_k[i] + 1;
        if (m_k[i] + 1 == lat_of(i)) m_res[i] <= m_vin[i];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("sample_en[%0d]", i), 32'(sample_en[i]), 32'(e_sample[i]));
        chk($sformatf("dac_code[%0d]", i), 32'(dac_code[i]), 32'(e_dac[i]));
        chk($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(e_busy[i]));
        chk($sformatf("valid[%0d]", i), 32'(valid[i]), 32'(e_valid[i]));
        chk($sformatf("result[%0d]", i), 32'(result[i]), 32'(m_res[i]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic launch(input logic [7:0] v);
    vin_next = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic [7:0] trace [8];
    int nvalid, drops;
    trace = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    noise = '{1'b0, 1'b0};
    repeat (3) @(negedge clk);
    checking = 1;
    rst = 1'b0;
    chk("reset_busy", 32'(busy[0]), 32'h0);
    chk("reset_dac", 32'(dac_code[0]), 32'h0);
    chk("reset_result", 32'(result[0]), 32'h0);

    // Vin 0xA5: fixed trial trace, valid at edge 20 (fast instance at edge 9)
    launch(8'hA5);
    for (int k = 0; k <= 21; k++) begin
      if (k >= 4 && k <= 18 && (k % 2 == 0)) begin
        chk("trace_dut", 32'(dac_code[0]), 32'(trace[(k - 4) / 2]));
        chk("trace_model", 32'(e_dac[0]), 32'(trace[(k - 4) / 2]));
      end
      if (k == 19) chk("lat_early", 32'(valid[0]), 32'h0);
      if (k == 20) begin
        chk("lat_valid", 32'(valid[0]), 32'h1);
        chk("res_a5", 32'(result[0]), 32'hA5);
      end
      if (k == 9) chk("fast_valid", 32'(valid[1]), 32'h1);
      noise = '{1'($urandom), 1'($urandom)};
      @(negedge clk);
    end

    // Fast instance, Vin 0x01: valid exactly at edge 9
    launch(8'h01);
    for (int k = 0; k <= 21; k++) begin
      if (k == 8) chk("fast01_early", 32'(valid[1]), 32'h0);
      if (k == 9) begin
        chk("fast01_valid", 32'(valid[1]), 32'h1);
        chk("fast01_res", 32'(result[1]), 32'h01);
      end
      @(negedge clk);
    end

    // Start held: back-to-back conversions every 21 edges, busy stays high
    vin_next = 8'h3C;
    start = 1'b1;
    nvalid = 0;
    drops = 0;
    @(negedge clk);
    for (int k = 0; k <= 62; k++) begin
      if (k == 59) start = 1'b0;
      if (valid[0]) begin
        nvalid++;
        chk("b2b_res", 32'(result[0]), 32'h3C);
        chk("b2b_edge", 32'(k % 21), 32'h20 - 32'h20 + 32'd20 - 32'(k / 21) * 0);
      end
      if (!busy[0]) drops++;
      @(negedge clk);
    end
    chk("b2b_count", 32'(nvalid), 32'd3);
    chk("b2b_busy", 32'(drops), 32'd0);
    repeat (25) @(negedge clk);

    // start pulses at edges 5 and 12 are ignored
    launch(8'h5A);
    nvalid = 0;
    for (int k = 0; k <= 25; k++) begin
      start = (k == 4 || k == 11);
      if (valid[0]) begin
        nvalid++;
        chk("ign_edge", 32'(k), 32'd20);
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("ign_count", 32'(nvalid), 32'd1);
    repeat (12) @(negedge clk);

    // Reset at edge 10 aborts with no valid
    launch(8'hC3);
    nvalid = 0;
    for (int k = 0; k <= 30; k++) begin
      rst = (k == 9);
      if (k == 10) begin
        chk("abort_busy", 32'(busy[0]), 32'h0);
        chk("abort_sample", 32'(sample_en[0]), 32'h0);
        chk("abort_result", 32'(result[0]), 32'h0);
      end
      if (valid[0]) nvalid++;
      @(negedge clk);
    end
    chk("abort_novalid", 32'(nvalid), 32'd0);

    // Randomized traffic with comparator noise outside decision edges
    for (int n = 0; n < 4000; n++) begin
      case ($urandom_range(0, 3))
        0: vin_next = 8'h00;
        1: vin_next = 8'hFF;
        default: vin_next = 8'($urandom);
      endcase
      start = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 299) == 0);
      noise = '{1'($urandom), 1'($urandom)};
      @(negedge clk);
    end
    start = 1'b0;
    rst = 1'b0;
    repeat (25) @(negedge clk);
    checking = 0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
